// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: sizing, ratio clamp and
// signed saturation.
package cic_pkg;

  localparam int RATIO_W = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [RATIO_W-1:0] clamp_ratio(
    input logic [RATIO_W-1:0] r,
    input int                 rmax
  );
    return (int'(r) > rmax) ? RATIO_W'(rmax) : r;
  endfunction

  function automatic logic signed [63:0] sat_s(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream bundle around the decimator: input samples plus
// ratio select towards the filter, decimated strobe back.
interface cic_decimator_if #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 19
);
  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic [2:0]       ratio_log2;
  logic [OUT_W-1:0] out;
  logic             out_valid;

  modport master (
    output in, in_valid, ratio_log2,
    input  out, out_valid
  );

  modport slave (
    input  in, in_valid, ratio_log2,
    output out, out_valid
  );
endinterface

// File: rtl/cic_comb_stage.sv
// One differentiator with a single-sample delay; output is the
// difference between the present input and the held one.
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] dly_q;
  logic [W-1:0] dly_d;

  always_comb begin
    dly_d = dly_q;
    if (clr) begin
      dly_d = '0;
    end else if (en) begin
      dly_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  assign dout = din - dly_q;
endmodule

// File: rtl/cic_decimator.sv
// CIC decimator: integrators at input rate, combs at output rate,
// gain normalised across ratios and saturated to OUT_W.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int  N_STAGES   = 3,
  parameter int  R_MAX_LOG2 = 6,
  parameter int  IN_W       = 1,
  localparam int OUT_W      = IN_W + N_STAGES * R_MAX_LOG2,
  localparam int ACC_W      = OUT_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    in,
  input  logic               in_valid,
  input  logic [RATIO_W-1:0] ratio_log2,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid
);
  localparam int CNT_W = (R_MAX_LOG2 > 0) ? R_MAX_LOG2 : 1;
  localparam int WU_W  = clog2(N_STAGES + 1);

  logic [RATIO_W-1:0] ratio_q, ratio_d, ratio_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d, mask;
  logic [WU_W-1:0]    warm_q, warm_d;
  logic [ACC_W-1:0]   comb_in_q, comb_in_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               tick_q, tick_d;
  logic               lat_q, lat_d;
  logic               out_valid_q, out_valid_d;

  logic [N_STAGES-1:0][ACC_W-1:0] integ_q, integ_d;
  logic [N_STAGES:0][ACC_W-1:0]   comb_c;

  logic                    chg;
  logic                    tick;
  logic                    comb_en;
  logic                    warm_done;
  logic [ACC_W-1:0]        x_ext;
  logic signed [ACC_W-1:0] norm;
  logic [OUT_W-1:0]        sat;
  int                      sh;

  if (IN_W == 1) begin : g_sd
    assign x_ext = in[0] ? ACC_W'(1) : '1;
  end else begin : g_pcm
    assign x_ext = {{(ACC_W - IN_W){in[IN_W-1]}}, in};
  end

  assign ratio_c   = clamp_ratio(ratio_log2, R_MAX_LOG2);
  assign chg       = (ratio_c != ratio_q);
  assign mask      = CNT_W'((32'd1 << ratio_q) - 32'd1);
  assign tick      = in_valid && (cnt_q == mask);
  assign comb_en   = lat_q && !chg;
  assign warm_done = (warm_q == WU_W'(N_STAGES));

  // Smaller ratios have less CIC gain; shift back up to a common scale.
  assign sh   = N_STAGES * (R_MAX_LOG2 - int'(ratio_q));
  assign norm = comb_c[N_STAGES] << sh;
  assign sat  = OUT_W'(sat_s(64'(norm), OUT_W));

  assign comb_c[0] = comb_in_q;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    cic_comb_stage #(
      .W (ACC_W)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (comb_en),
      .clr  (chg),
      .din  (comb_c[g]),
      .dout (comb_c[g+1])
    );
  end

  always_comb begin
    ratio_d     = ratio_c;
    cnt_d       = cnt_q;
    integ_d     = integ_q;
    tick_d      = 1'b0;
    lat_d       = 1'b0;
    comb_in_d   = comb_in_q;
    warm_d      = warm_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (chg) begin
      cnt_d     = '0;
      integ_d   = '0;
      comb_in_d = '0;
      warm_d    = '0;
    end else begin
      if (in_valid) begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        integ_d[0] = integ_q[0] + x_ext;
        for (int i = 1; i < N_STAGES; i++) begin
          integ_d[i] = integ_q[i] + integ_q[i-1];
        end
      end
      tick_d = tick;
      lat_d  = tick_q;
      if (tick_q) begin
        comb_in_d = integ_q[N_STAGES-1];
      end
      // Values during warm-up still land on out, only the strobe is held.
      if (lat_q) begin
        out_d = sat;
        if (warm_done) begin
          out_valid_d = 1'b1;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio_q     <= RATIO_W'(R_MAX_LOG2);
      cnt_q       <= '0;
      integ_q     <= '0;
      tick_q      <= 1'b0;
      lat_q       <= 1'b0;
      comb_in_q   <= '0;
      warm_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ratio_q     <= ratio_d;
      cnt_q       <= cnt_d;
      integ_q     <= integ_d;
      tick_q      <= tick_d;
      lat_q       <= lat_d;
      comb_in_q   <= comb_in_d;
      warm_q      <= warm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter N_STAGES, default 3: number of integrator stages and number of comb stages (1..6).
REQ-002 SHALL have parameter R_MAX_LOG2, default 6: maximum decimation ratio, 2^R_MAX_LOG2.
REQ-003 SHALL have parameter IN_W, default 1: input width. IN_W=1 means a 1-bit sigma-delta stream; IN_W>1 means signed two's complement.
REQ-004 SHALL derive localparam OUT_W = IN_W + N_STAGES*R_MAX_LOG2 (19 at defaults) and ACC_W = OUT_W + 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in, input, IN_W bits: input sample.
REQ-008 SHALL have port in_valid, input, 1 bit: `in` is accepted on each rising edge where this is 1.
REQ-009 SHALL have port ratio_log2, input, 3 bits: selected decimation ratio R = 2^ratio_log2. Legal range 1..R_MAX_LOG2; values above R_MAX_LOG2 are clamped to R_MAX_LOG2.
REQ-010 SHALL have port out, output, OUT_W bits: signed decimated sample.
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle strobe marking a new value on `out`.

Function
REQ-012 SHALL map the input as follows: for IN_W=1, 1 maps to +1 and 0 maps to -1; for IN_W>1, `in` is sign-extended to ACC_W.
REQ-013 SHALL implement N_STAGES cascaded integrators, each an ACC_W-bit register.
- All integrators update only on edges where in_valid=1.
- Each stage adds its input to its own value, modulo 2^ACC_W (wrap-around is required; no saturation).
REQ-014 SHALL keep a sample counter, 0..R-1, that increments on each accepted sample and wraps to 0.
- The edge that accepts the sample taking the counter from R-1 to 0 is the decimation tick.
REQ-015 SHALL, one edge after a tick, latch the last integrator's value into the comb section.
- The comb section is N_STAGES differential stages with delay M=1, ACC_W wide, modulo 2^ACC_W.
REQ-016 SHALL update `out` and pulse out_valid on the second rising edge after the tick edge, giving a fixed latency of 2 clocks.
- This latency is independent of in_valid activity after the tick.
REQ-017 SHALL normalise gain by shifting the comb result left by N_STAGES*(R_MAX_LOG2-ratio_log2), so full scale is identical for every ratio.
REQ-018 SHALL saturate the normalised ACC_W-bit result to OUT_W signed bits.
- +2^(OUT_W-1) becomes 2^(OUT_W-1)-1.
- The negative full-scale value is passed unchanged.
REQ-019 SHALL suppress out_valid for the first N_STAGES ticks after reset or after a ratio change. This is comb warm-up; `out` still updates internally during these ticks.
REQ-020 SHALL register the active ratio.
- On any edge where the clamped ratio_log2 differs from the active ratio: clear all integrators, combs, the counter and the warm-up count; discard the sample on that edge; load the new ratio.
- Any pending output from an earlier tick is dropped.
REQ-021 SHALL accept in_valid=1 on every clock (full-rate input) with no stall. The block has no back-pressure.
REQ-022 SHALL hold `out` between strobes.

Reset
REQ-023 SHALL, while rst_n=0, clear asynchronously: all integrators, combs, the counter, the warm-up count and the pipeline flags.
REQ-024 SHALL, while rst_n=0, drive out=0 and out_valid=0, and load the active ratio with R_MAX_LOG2.
REQ-025 SHALL, when reset is asserted mid-operation, abort any pending output with no out_valid pulse. The first strobe after release follows REQ-019.

Structure
REQ-026 SHALL place the following in shared package cic_pkg: a clog2 function, the ratio clamp function, and the saturate-to-width function.
REQ-027 SHALL implement each comb stage as sub-module cic_comb_stage: width parameter, enable, clear, and a 1-deep delay register. It is instantiated N_STAGES times via generate.

Verification
REQ-028 SHALL test constant input 1, R=64, in_valid=1 continuously. Required response: out_valid every 64 clocks; first strobe at tick 4; out = 0x3FFFF (saturated).
REQ-029 SHALL test constant input 0, R=64. Required response: out = 0x40000 (-262144) after warm-up.
REQ-030 SHALL test alternating 1,0 at R=8. Required response: out = 0 after warm-up; strobes every 8 clocks.
REQ-031 SHALL test in_valid=1 one clock in three, constant input 1, R=16. Required response: strobe every 48 clocks; out = 0x3FFFF; each strobe exactly 2 clocks after the tick edge.
REQ-032 SHALL test a switch of ratio_log2 from 6 to 3 mid-stream. Required response: no strobe for the next 3 ticks; then correct R=8 output. Also test rst_n pulsed low for 1 clock mid-frame: out=0, no strobe until 3 ticks after release.
REQ-033 SHALL test a 1 kHz sigma-delta sine file at clk period 156.25 ns and R=64. Required response: output matches the golden model bit-exactly.
